// File: rtl/sar_search_ctrl_pkg.sv
// Shared encodings for the successive-approximation search controller.
// Comparator codes are the {E, G, L} triple sampled from the external comparator.
package sar_search_ctrl_pkg;

    typedef enum logic [1:0] {
        SarIdle = 2'd0,
        SarTry  = 2'd1,
        SarDone = 2'd2
    } sar_state_e;

    localparam logic [2:0] CmpE = 3'b100;
    localparam logic [2:0] CmpG = 3'b010;
    localparam logic [2:0] CmpL = 3'b001;

    function automatic logic cmp_legal(input logic [2:0] code);
        return (code == CmpE) || (code == CmpG) || (code == CmpL);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes into an external
// combinational comparator and resolves the unknown target MSB-first, one bit per clock.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_e,
    input  logic             cmp_g,
    input  logic             cmp_l,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int unsigned     IdxW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TrialInit = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IdxW-1:0]  IdxInit   = IdxW'(WIDTH - 1);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic [2:0]       cmp_code;
    logic [WIDTH-1:0] trial_upd;
    logic [IdxW-1:0]  idx_dec;

    assign cmp_code = {cmp_e, cmp_g, cmp_l};
    assign idx_dec  = idx_q - IdxW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SarIdle;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        idx_d     = idx_q;
        found_d   = found_q;
        err_d     = err_q;
        trial_upd = trial_q;

        unique case (state_q)
            SarIdle: begin
                if (start) begin
                    trial_d = TrialInit;
                    idx_d   = IdxInit;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = SarTry;
                end
            end
            SarTry: begin
                if (!cmp_legal(cmp_code)) begin
                    result_d = trial_q;
                    err_d    = 1'b1;
                    state_d  = SarDone;
                end else if (cmp_code == CmpE) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    state_d  = SarDone;
                end else begin
                    // Trial above target: this bit must be 0 in the answer.
                    if (cmp_code == CmpG) begin
                        trial_upd[idx_q] = 1'b0;
                    end
                    if (idx_q == '0) begin
                        result_d = trial_upd;
                        found_d  = 1'b0;
                        state_d  = SarDone;
                    end else begin
                        trial_upd[idx_dec] = 1'b1;
                        trial_d            = trial_upd;
                        idx_d              = idx_dec;
                    end
                end
            end
            SarDone: begin
                state_d = SarIdle;
            end
            default: begin
                state_d = SarIdle;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = (state_q != SarIdle);
    assign done   = (state_q == SarDone);
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule
